// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Lookup is combinational on the fetch PC; EX resolution updates on the next edge.
module branch_target_predictor #(
  parameter int PC_W    = 32,
  parameter int INDEX_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [1:0]      ex_kind,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_mispredict,
  output logic [31:0]     mispred_cnt
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = PC_W - INDEX_W - 2;

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [PC_W-1:0]   r_target [ENTRIES];
  logic              r_uncond [ENTRIES];
  logic [1:0]        r_ctr    [ENTRIES];
  logic [31:0]       r_mis_cnt;

  logic [INDEX_W-1:0] w_if_idx;
  logic [TAG_W-1:0]   w_if_tag;
  logic [INDEX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0]   w_ex_tag;
  logic               w_ex_hit;
  logic               w_upd;
  logic [1:0]         w_ctr_cur;
  logic [1:0]         w_ctr_inc;
  logic [1:0]         w_ctr_dec;
  logic               w_unused;

  assign w_if_idx = if_pc[INDEX_W+1:2];
  assign w_if_tag = if_pc[PC_W-1:INDEX_W+2];
  assign w_ex_idx = ex_pc[INDEX_W+1:2];
  assign w_ex_tag = ex_pc[PC_W-1:INDEX_W+2];
  assign w_unused = ^{if_pc[1:0], ex_pc[1:0]};

  always_comb begin
    pred_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    pred_taken  = pred_hit && (r_uncond[w_if_idx] || r_ctr[w_if_idx][1]);
    pred_target = pred_hit ? r_target[w_if_idx] : '0;
  end

  assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_upd     = ex_valid && (ex_kind != 2'b00);
  assign w_ctr_cur = r_ctr[w_ex_idx];
  assign w_ctr_inc = (w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'd1;
  assign w_ctr_dec = (w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_uncond[i] <= 1'b0;
        r_ctr[i]    <= 2'b01;
      end
      r_mis_cnt <= '0;
    end else begin
      if (ex_valid && ex_mispredict && (r_mis_cnt != 32'hFFFF_FFFF))
        r_mis_cnt <= r_mis_cnt + 32'd1;
      if (w_upd) begin
        if (!w_ex_hit) begin
          // Only taken outcomes allocate; an alias victim is fully replaced
          if (ex_taken) begin
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= ex_target;
            r_uncond[w_ex_idx] <= (ex_kind != 2'b01);
            r_ctr[w_ex_idx]    <= 2'b10;
          end
        end else if (ex_taken) begin
          r_ctr[w_ex_idx]    <= w_ctr_inc;
          r_target[w_ex_idx] <= ex_target;
        end else begin
          r_ctr[w_ex_idx] <= w_ctr_dec;
          if (ex_kind == 2'b11)
            r_target[w_ex_idx] <= ex_target;
        end
      end
    end
  end

  assign mispred_cnt = r_mis_cnt;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor.
// Expected lookups go through a queue and are checked when sampled.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  ex_kind;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_mispredict;
  logic [31:0] mispred_cnt;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_cnt = 0;

  always #5 clk = ~clk;

  branch_target_predictor dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_kind       (ex_kind),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .ex_mispredict (ex_mispredict),
    .mispred_cnt   (mispred_cnt)
  );

  task automatic check_pred();
    exp_t e;
    e = exp_q.pop_front();
    n_total++;
    assert (pred_hit === e.hit && pred_taken === e.taken &&
            pred_target === e.tgt) n_pass++;
    else $error("FAIL %s: hit/taken/target=%b/%b/%h expected %b/%b/%h",
                e.name, pred_hit, pred_taken, pred_target,
                e.hit, e.taken, e.tgt);
  endtask

  task automatic check_cnt(input string name);
    n_total++;
    assert (mispred_cnt === exp_cnt) n_pass++;
    else $error("FAIL %s: mispred_cnt=%0d expected %0d",
                name, mispred_cnt, exp_cnt);
  endtask

  task automatic look(input string name, input logic [31:0] pc,
                      input logic h, input logic tk,
                      input logic [31:0] tg);
    @(negedge clk);
    if_pc = pc;
    exp_q.push_back('{name, h, tk, tg});
    #1;
    check_pred();
  endtask

  task automatic upd(input logic v, input logic [1:0] k,
                     input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg, input logic mis);
    @(negedge clk);
    ex_valid      = v;
    ex_kind       = k;
    ex_pc         = pc;
    ex_taken      = tk;
    ex_target     = tg;
    ex_mispredict = mis;
    @(posedge clk);
    #1;
    if (v && mis && !rst) exp_cnt++;
    ex_valid      = 1'b0;
    ex_mispredict = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if_pc = '0;
    ex_valid = 1'b0;
    ex_pc = '0;
    ex_kind = 2'b00;
    ex_taken = 1'b0;
    ex_target = '0;
    ex_mispredict = 1'b0;

    // Reset: outputs clear while rst still high, then sweep
    @(posedge clk);
    look("rst_hold", 32'h100, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++)
      look("rst_sweep", 32'(i * 4), 1'b0, 1'b0, 32'h0);
    check_cnt("rst_cnt");

    // B-type allocate and counter walk
    upd(1'b1, 2'b01, 32'h100, 1'b1, 32'h80, 1'b0);
    look("b_alloc", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(1'b1, 2'b01, 32'h100, 1'b0, 32'h80, 1'b0);
    look("b_nt1", 32'h100, 1'b1, 1'b0, 32'h80);
    upd(1'b1, 2'b01, 32'h100, 1'b0, 32'h80, 1'b0);
    look("b_nt2", 32'h100, 1'b1, 1'b0, 32'h80);
    upd(1'b1, 2'b01, 32'h100, 1'b1, 32'h80, 1'b0);
    look("b_t1", 32'h100, 1'b1, 1'b0, 32'h80);
    upd(1'b1, 2'b01, 32'h100, 1'b1, 32'h80, 1'b0);
    look("b_t2", 32'h100, 1'b1, 1'b1, 32'h80);

    // JAL stays taken; not-taken hit keeps target
    upd(1'b1, 2'b10, 32'h40, 1'b1, 32'h200, 1'b0);
    look("jal_alloc", 32'h40, 1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 5; i++)
      upd(1'b1, 2'b10, 32'h40, 1'b0, 32'h0, 1'b0);
    look("jal_uncond", 32'h40, 1'b1, 1'b1, 32'h200);

    // JALR retargets
    upd(1'b1, 2'b11, 32'h44, 1'b1, 32'h300, 1'b0);
    look("jalr_a", 32'h44, 1'b1, 1'b1, 32'h300);
    upd(1'b1, 2'b11, 32'h44, 1'b1, 32'h400, 1'b0);
    look("jalr_b", 32'h44, 1'b1, 1'b1, 32'h400);

    // Alias at index 0
    upd(1'b1, 2'b01, 32'h1100, 1'b1, 32'h700, 1'b0);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h0);
    look("alias_new", 32'h1100, 1'b1, 1'b1, 32'h700);

    // Not-taken miss never allocates
    upd(1'b1, 2'b01, 32'h180, 1'b0, 32'h900, 1'b0);
    look("nt_noalloc", 32'h180, 1'b0, 1'b0, 32'h0);

    // Same-cycle lookup sees pre-update state
    @(negedge clk);
    ex_valid  = 1'b1;
    ex_kind   = 2'b01;
    ex_pc     = 32'h180;
    ex_taken  = 1'b1;
    ex_target = 32'h904;
    if_pc     = 32'h180;
    exp_q.push_back('{"same_cyc", 1'b0, 1'b0, 32'h0});
    #1;
    check_pred();
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    look("same_next", 32'h180, 1'b1, 1'b1, 32'h904);

    // Mispredict counting; kind 00 writes nothing
    upd(1'b1, 2'b00, 32'h1C0, 1'b1, 32'h123, 1'b1);
    look("kind0_nowrite", 32'h1C0, 1'b0, 1'b0, 32'h0);
    check_cnt("cnt_1");
    upd(1'b0, 2'b01, 32'h1C0, 1'b1, 32'h123, 1'b1);
    look("invalid_nowrite", 32'h1C0, 1'b0, 1'b0, 32'h0);
    check_cnt("cnt_invalid");
    upd(1'b1, 2'b01, 32'h40, 1'b1, 32'h200, 1'b1);
    upd(1'b1, 2'b01, 32'h40, 1'b1, 32'h200, 1'b1);
    check_cnt("cnt_3");

    // Reset dominates a concurrent update
    @(negedge clk);
    rst = 1'b1;
    upd(1'b1, 2'b10, 32'h240, 1'b1, 32'h555, 1'b1);
    exp_cnt = 0;
    rst = 1'b0;
    look("rst_upd_new", 32'h240, 1'b0, 1'b0, 32'h0);
    look("rst_upd_a", 32'h1100, 1'b0, 1'b0, 32'h0);
    look("rst_upd_b", 32'h40, 1'b0, 1'b0, 32'h0);
    look("rst_upd_c", 32'h44, 1'b0, 1'b0, 32'h0);
    look("rst_upd_d", 32'h180, 1'b0, 1'b0, 32'h0);
    check_cnt("rst_upd_cnt");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
